// File: rtl/psys_route_arb.sv
// psys_route_arb: round-robin arbiter that grants whole BEATS-beat bursts from NUM_SRC
// AXI-Stream sources into a one-deep registered output stage, with tlast framing checks.
module psys_route_arb #(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned BEATS   = 12,
   parameter int unsigned ID_W    = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_SRC-1:0]       src_en,
   input  logic [NUM_SRC*128-1:0]   s_axis_tdata,
   input  logic [NUM_SRC-1:0]       s_axis_tvalid,
   output logic [NUM_SRC-1:0]       s_axis_tready,
   input  logic [NUM_SRC-1:0]       s_axis_tlast,
   output logic [127:0]             m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [ID_W-1:0]          m_axis_tid,
   output logic                     burst_done,
   output logic                     err_tlast
);

   localparam int unsigned DATA_W = 128;
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ID_W-1:0]  LAST_SRC  = ID_W'(NUM_SRC - 1);

   typedef enum logic {IDLE, BURST} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   id;
      logic              last;
   } beat_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [ID_W-1:0]    last_grant_q, last_grant_d;
   beat_t              out_q;
   logic               out_valid_q;
   logic               done_q;
   logic               err_q;

   logic [DATA_W-1:0]  src_data [NUM_SRC];
   logic [NUM_SRC-1:0] cand;
   logic [NUM_SRC-1:0] ready_c;
   logic [SEL_W-1:0]   rr_idx;
   logic [SEL_W-1:0]   rr_sel;
   logic               rr_found;
   logic [SEL_W-1:0]   grant_sel;
   logic               grant_valid;
   logic               out_ready;
   logic               accept;
   logic               at_last;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign src_data[g] = s_axis_tdata[g*DATA_W +: DATA_W];
   end

   assign cand      = s_axis_tvalid & src_en;
   assign out_ready = ~out_valid_q | m_axis_tready;

   // First candidate strictly after last_grant, wrapping modulo NUM_SRC
   always_comb begin
      rr_idx   = '0;
      rr_sel   = '0;
      rr_found = 1'b0;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         rr_idx = SEL_W'((32'(last_grant_q) + k) % NUM_SRC);
         if (!rr_found && cand[rr_idx]) begin
            rr_found = 1'b1;
            rr_sel   = rr_idx;
         end
      end
   end

   // Next-state, grant and per-source ready
   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      last_grant_d = last_grant_q;
      grant_sel    = SEL_W'(last_grant_q);
      grant_valid  = 1'b1;
      ready_c      = '0;

      if (state_q == IDLE) begin
         grant_sel   = rr_sel;
         grant_valid = rr_found;
      end

      ready_c[grant_sel] = grant_valid & out_ready & rst_n;
      accept             = ready_c[grant_sel] & s_axis_tvalid[grant_sel];
      at_last            = (beat_cnt_q == LAST_BEAT);

      if (accept) begin
         if (state_q == IDLE) begin
            last_grant_d = ID_W'(grant_sel);
         end
         if (at_last) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
         end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            state_d    = BURST;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         last_grant_q <= LAST_SRC;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Output register, burst completion pulse and sticky framing error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= accept & at_last;
         if (accept) begin
            out_q.data  <= src_data[grant_sel];
            out_q.id    <= ID_W'(grant_sel);
            out_q.last  <= at_last;
            out_valid_q <= 1'b1;
         end else if (m_axis_tready) begin
            out_valid_q <= 1'b0;
         end
         if (accept && (s_axis_tlast[grant_sel] != at_last)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign s_axis_tready = ready_c;
   assign m_axis_tdata  = out_q.data;
   assign m_axis_tid    = out_q.id;
   assign m_axis_tlast  = out_q.last;
   assign m_axis_tvalid = out_valid_q;
   assign burst_done    = done_q;
   assign err_tlast     = err_q;

endmodule

// File: tb/tb_psys_route_arb.sv
// tb_psys_route_arb: grant-table vectors, directed burst sequences and randomized traffic
// checked against a queue-based burst/round-robin reference model.
module tb_psys_route_arb;

   localparam int unsigned NUM_SRC = 3;
   localparam int unsigned BEATS   = 12;
   localparam int unsigned ID_W    = 3;

   logic                   clk;
   logic                   rst_n;
   logic [NUM_SRC-1:0]     src_en;
   logic [NUM_SRC*128-1:0] s_axis_tdata;
   logic [NUM_SRC-1:0]     s_axis_tvalid;
   logic [NUM_SRC-1:0]     s_axis_tready;
   logic [NUM_SRC-1:0]     s_axis_tlast;
   logic [127:0]           m_axis_tdata;
   logic                   m_axis_tvalid;
   logic                   m_axis_tready;
   logic                   m_axis_tlast;
   logic [ID_W-1:0]        m_axis_tid;
   logic                   burst_done;
   logic                   err_tlast;

   psys_route_arb #(.NUM_SRC(NUM_SRC), .BEATS(BEATS), .ID_W(ID_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .src_en        (src_en),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tid    (m_axis_tid),
      .burst_done    (burst_done),
      .err_tlast     (err_tlast)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [127:0] data;
      int           id;
      bit           last;
   } exp_beat_t;

   typedef struct {
      logic [2:0] en;
      logic [2:0] valid;
      logic       mrdy;
      logic [2:0] rdy;
   } vec_t;

   int        errors = 0;
   int        checks = 0;
   exp_beat_t obuf[$];
   int        tid_log[$];
   int        sent[NUM_SRC];
   int        prev, owner, pos;
   bit        done_exp, err_exp;
   int        fires, cyc;

   logic [NUM_SRC-1:0] want_valid, en;
   int tr_mode;
   bit rand_valid, rand_err;
   int stall_src, stall_at, stall_left, err_src, err_beat;

   function automatic logic [127:0] mkdata(int src, int seq);
      return {32'(src), 32'(seq), 32'(seq) ^ 32'h5A5A_A5A5, 32'(src * 7919 + seq * 31)};
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      obuf.delete();
      prev     = NUM_SRC - 1;
      owner    = 0;
      pos      = 0;
      done_exp = 1'b0;
      err_exp  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) sent[i] = 0;
   endfunction

   function automatic void knobs_default();
      want_valid = '0;
      en         = '1;
      tr_mode    = 0;
      rand_valid = 1'b0;
      rand_err   = 1'b0;
      stall_src  = -1;
      stall_at   = 0;
      stall_left = 0;
      err_src    = -1;
      err_beat   = 0;
   endfunction

   // Source behaviour: each source streams its own numbered beats, tlast every BEATS beats
   task automatic apply();
      bit v;
      case (tr_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = (cyc % 2 == 1);
         default: m_axis_tready = ($urandom_range(0, 9) < 7);
      endcase
      src_en = en;
      for (int i = 0; i < NUM_SRC; i++) begin
         v = want_valid[i];
         if (rand_valid && $urandom_range(0, 3) == 0) v = 1'b0;
         if (i == stall_src && sent[i] == stall_at && stall_left > 0) begin
            v = 1'b0;
            stall_left--;
         end
         s_axis_tvalid[i]          = v;
         s_axis_tdata[i*128 +: 128] = mkdata(i, sent[i]);
         s_axis_tlast[i] = ((sent[i] % BEATS) == BEATS - 1)
                         ^ (i == err_src && sent[i] == err_beat)
                         ^ (rand_err && $urandom_range(0, 63) == 0);
      end
   endtask

   // Reference model: one-deep output queue, whole-burst ownership, round-robin after prev
   task automatic check_cycle();
      logic [NUM_SRC-1:0] cand, exp_rdy;
      bit        oready, found;
      int        j;
      exp_beat_t b;
      chk("m_axis_tvalid", 128'(m_axis_tvalid), 128'(obuf.size() != 0));
      if (obuf.size() != 0) begin
         chk("m_axis_tdata", m_axis_tdata, obuf[0].data);
         chk("m_axis_tid", 128'(m_axis_tid), 128'(obuf[0].id));
         chk("m_axis_tlast", 128'(m_axis_tlast), 128'(obuf[0].last));
      end
      chk("burst_done", 128'(burst_done), 128'(done_exp));
      chk("err_tlast", 128'(err_tlast), 128'(err_exp));

      oready  = (obuf.size() == 0) || m_axis_tready;
      exp_rdy = '0;
      found   = 1'b0;
      if (oready) begin
         if (pos == 0) begin
            cand = s_axis_tvalid & src_en;
            for (int k = 1; k <= NUM_SRC; k++) begin
               j = (prev + k) % NUM_SRC;
               if (!found && cand[j]) begin
                  exp_rdy[j] = 1'b1;
                  found      = 1'b1;
               end
            end
         end else begin
            exp_rdy[owner] = 1'b1;
         end
      end
      chk("s_axis_tready", 128'(s_axis_tready), 128'(exp_rdy));

      if (m_axis_tvalid && m_axis_tready) begin
         fires++;
         if (m_axis_tlast) tid_log.push_back(int'(m_axis_tid));
      end
      if (obuf.size() != 0 && m_axis_tready) void'(obuf.pop_front());

      done_exp = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (exp_rdy[i] && s_axis_tvalid[i]) begin
            b.data = mkdata(i, sent[i]);
            b.id   = i;
            b.last = (pos == BEATS - 1);
            obuf.push_back(b);
            if (s_axis_tlast[i] != b.last) err_exp = 1'b1;
            if (pos == 0) begin
               prev  = i;
               owner = i;
            end
            pos++;
            if (pos == BEATS) begin
               pos      = 0;
               done_exp = 1'b1;
            end
         end
      end
      for (int i = 0; i < NUM_SRC; i++)
         if (s_axis_tvalid[i] && s_axis_tready[i]) sent[i]++;
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      cyc++;
      apply();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      fires = 0;
      cyc   = 0;
      tid_log.delete();
      apply();
   endtask

   task automatic wait_pos(string nm, int src, int p);
      int k;
      k = 0;
      while (!(owner == src && pos == p) && k < 200) begin
         step();
         k++;
      end
      chk(nm, 128'(owner == src && pos == p), 128'(1));
   endtask

   task automatic check_log(string nm, int n, int e0, int e1, int e2, int e3);
      int e[4];
      e = '{e0, e1, e2, e3};
      chk({nm, " burst count"}, 128'(tid_log.size() >= n), 128'(1));
      for (int i = 0; i < n; i++)
         if (i < tid_log.size())
            chk($sformatf("%s tid[%0d]", nm, i), 128'(tid_log[i]), 128'(e[i]));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[8];
      tbl[0] = '{en: 3'b111, valid: 3'b111, mrdy: 1'b1, rdy: 3'b001};
      tbl[1] = '{en: 3'b111, valid: 3'b110, mrdy: 1'b0, rdy: 3'b010};
      tbl[2] = '{en: 3'b111, valid: 3'b100, mrdy: 1'b1, rdy: 3'b100};
      tbl[3] = '{en: 3'b101, valid: 3'b110, mrdy: 1'b1, rdy: 3'b100};
      tbl[4] = '{en: 3'b110, valid: 3'b011, mrdy: 1'b0, rdy: 3'b010};
      tbl[5] = '{en: 3'b000, valid: 3'b111, mrdy: 1'b1, rdy: 3'b000};
      tbl[6] = '{en: 3'b111, valid: 3'b000, mrdy: 1'b1, rdy: 3'b000};
      tbl[7] = '{en: 3'b011, valid: 3'b101, mrdy: 1'b1, rdy: 3'b001};

      // Reset values with all sources pushing
      knobs_default();
      want_valid = '1;
      rst_n      = 1'b0;
      cyc        = 0;
      model_reset();
      apply();
      @(posedge clk);
      #1;
      chk("reset s_axis_tready", 128'(s_axis_tready), 128'(0));
      chk("reset m_axis_tvalid", 128'(m_axis_tvalid), 128'(0));
      chk("reset m_axis_tdata", m_axis_tdata, 128'(0));
      chk("reset m_axis_tid", 128'(m_axis_tid), 128'(0));
      chk("reset m_axis_tlast", 128'(m_axis_tlast), 128'(0));
      chk("reset burst_done", 128'(burst_done), 128'(0));
      chk("reset err_tlast", 128'(err_tlast), 128'(0));

      // Idle grant table from reset priority (source 0 first)
      knobs_default();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         src_en        = tbl[i].en;
         s_axis_tvalid = tbl[i].valid;
         m_axis_tready = tbl[i].mrdy;
         #3;
         chk($sformatf("grant table[%0d]", i), 128'(s_axis_tready), 128'(tbl[i].rdy));
         s_axis_tvalid = '0;
      end

      // Post-reset round robin, back-to-back bursts
      knobs_default();
      want_valid = '1;
      do_reset();
      run(50);
      check_log("rr order", 4, 0, 1, 2, 0);
      chk("rr no bubbles", 128'(fires), 128'(49));

      // Held valid under toggling ready, late requester waits for burst end
      knobs_default();
      want_valid = 3'b010;
      tr_mode    = 1;
      do_reset();
      run(6);
      want_valid = 3'b110;
      run(70);
      check_log("held valid", 2, 1, 2, 0, 0);

      // Source 0 stalls after beat 5 for 10 cycles, source 1 must not be granted
      knobs_default();
      want_valid = 3'b011;
      stall_src  = 0;
      stall_at   = 6;
      stall_left = 10;
      do_reset();
      run(50);
      chk("stall consumed", 128'(stall_left), 128'(0));
      check_log("stall", 2, 0, 1, 0, 0);

      // Early tlast on beat 4 of source 2
      knobs_default();
      want_valid = 3'b100;
      err_src    = 2;
      err_beat   = 4;
      do_reset();
      run(30);
      chk("err_tlast set", 128'(err_tlast), 128'(1));
      check_log("tlast err", 1, 2, 0, 0, 0);
      run(20);
      chk("err_tlast sticky", 128'(err_tlast), 128'(1));

      // Enable mask 101, then drop src_en[0] inside a source-0 burst
      knobs_default();
      want_valid = '1;
      en         = 3'b101;
      do_reset();
      run(52);
      check_log("en mask", 4, 0, 2, 0, 2);
      wait_pos("en wait src0 beat3", 0, 3);
      en = 3'b100;
      tid_log.delete();
      run(40);
      check_log("en drop", 3, 0, 2, 2, 0);

      // Reset asserted with beat 7 pending
      knobs_default();
      want_valid = '1;
      do_reset();
      wait_pos("reset wait beat7", 0, 7);
      rst_n = 1'b0;
      #1;
      chk("mid reset m_axis_tvalid", 128'(m_axis_tvalid), 128'(0));
      chk("mid reset s_axis_tready", 128'(s_axis_tready), 128'(0));
      do_reset();
      run(30);
      check_log("after reset", 1, 0, 0, 0, 0);

      // Randomized traffic, enables, backpressure and framing errors
      knobs_default();
      want_valid = '1;
      rand_valid = 1'b1;
      rand_err   = 1'b1;
      tr_mode    = 2;
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         if (i % 64 == 0) en = 3'($urandom_range(1, 7));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/psys_route_arb.md
# psys_route_arb

Round-robin arbiter that shares the 128-bit packing path of the data-route stage between up to `NUM_SRC` AXI-Stream producers (weight, activation, bias DMA channels). The packing path assembles 12 beats into one 1536-bit systolic word, so the arbiter grants in whole 12-beat bursts and never interleaves sources inside a word. It sits between the DMA read channels and the 128-to-1536 width converter. It carries a one-deep registered output stage and reports framing errors.

## Interface
- `NUM_SRC`, 3: number of requesting sources, 2..8.
- `BEATS`, 12: beats per burst, equal to 1536/128.
- `ID_W`, 3: width of the source index, at least clog2(`NUM_SRC`).

- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `src_en`  in  `NUM_SRC`  per-source enable, sampled only at arbitration.
- `s_axis_tdata`  in  `NUM_SRC`*128  source data; source i occupies [128i+127:128i].
- `s_axis_tvalid`  in  `NUM_SRC`  per-source valid.
- `s_axis_tready`  out  `NUM_SRC`  per-source ready; combinational; at most one bit high.
- `s_axis_tlast`  in  `NUM_SRC`  per-source last; expected only on beat `BEATS`-1.
- `m_axis_tdata`  out  128  data to the width converter.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  converter ready.
- `m_axis_tlast`  out  1  high on beat `BEATS`-1 of every burst, generated internally.
- `m_axis_tid`  out  `ID_W`  source index of the current beat.
- `burst_done`  out  1  one-cycle pulse when the last beat of a burst is accepted from the source.
- `err_tlast`  out  1  sticky; cleared only by reset.

## Operation
- **State machine, IDLE:**
  - Candidate set is `s_axis_tvalid & src_en`.
  - Grant goes to the first candidate found searching from `last_grant+1` upward, wrapping modulo `NUM_SRC`.
  - The grant is combinational, so the first beat is accepted in the IDLE cycle if the output stage can take it.
  - On that acceptance: `last_grant` is set to the winner, `beat_cnt` becomes 1, and the state moves to BURST.
  - If no source is a candidate, or the output stage is full, the block stays in IDLE and `last_grant` is unchanged.
- **State machine, BURST:**
  - The grant is locked to `last_grant`.
  - `s_axis_tready[last_grant]` is driven by the output-stage ready; all other ready bits are 0.
  - Each accepted beat increments `beat_cnt`.
  - Accepting beat `BEATS`-1 pulses `burst_done`, clears `beat_cnt` and returns to IDLE.
  - If the granted source deasserts valid, the block waits. There is no timeout and no preemption.
  - Deasserting `src_en` mid-burst has no effect until the burst ends.
- **Output stage:**
  - Register holding data, id, last and a valid flag.
  - `out_ready = ~m_axis_tvalid | m_axis_tready`.
  - On source acceptance the register loads data, `tid = grant` and `tlast = (beat_cnt == BEATS-1)`.
  - If `m_axis_tready` is high and nothing new is accepted, `m_axis_tvalid` clears.
- **tlast checking:**
  - `s_axis_tlast` is not forwarded.
  - `err_tlast` sets when an accepted beat has `s_axis_tlast` high with `beat_cnt != BEATS-1`, or low with `beat_cnt == BEATS-1`.
  - The burst still runs to exactly `BEATS` beats, so the output word alignment is preserved.
- **Widths:**
  - `beat_cnt` is clog2(`BEATS`) bits and never exceeds `BEATS`-1.
  - `last_grant` is `ID_W` bits and always holds a value below `NUM_SRC`.

## Timing
- **Reset values:**
  - `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast`, `m_axis_tid`, `burst_done`, `err_tlast` = 0.
  - State = IDLE, `beat_cnt` = 0, `last_grant` = `NUM_SRC`-1, so source 0 has first priority.
  - `s_axis_tready` is forced to all zeros while `rst_n` is low.
- **Reset mid-operation:** reset asserted mid-burst drops the partial burst and the output register immediately. No beat is emitted after reset.
- **Latency:** 1 cycle from source acceptance to `m_axis_tvalid`.
- **Throughput:**
  - Sustained rate is 1 beat/cycle with `m_axis_tready` held high, including across burst boundaries (no bubble between bursts).
  - The boundary is handled by IDLE's same-cycle grant.
- **Simultaneous events:** output accept and new load in the same cycle is legal. The register loads, and valid stays 1.
- **Backpressure:** `m_axis_tready` low with the register full gives `s_axis_tready` = 0 the same cycle. Output data holds stable.
- **AXI rules:**
  - `s_axis_tready` may depend on `s_axis_tvalid` in IDLE.
  - `m_axis_tvalid` never depends combinationally on `m_axis_tready`.
- **`burst_done` timing:** asserted in the cycle after the last source beat is accepted.

## Test plan
- **Post-reset grant:** reset, then sources 0, 1 and 2 all valid, `m_axis_tready` = 1 → bursts appear with `m_axis_tid` in order 0,1,2,0. Each burst is 12 beats with `m_axis_tlast` on beats 11, 23, 35. There are no idle cycles between bursts.
- **Held valid:** only source 1 is valid and `m_axis_tready` is toggled 1,0 every cycle → exactly 12 beats per burst. Data matches the source sequence, and the burst stays locked to id 1. With source 2 raising valid mid-burst, source 2 is granted only after beat 11.
- **Stall:** source 0 drops valid after beat 5 for 10 cycles → no other source is granted meanwhile, and the burst resumes at beat 6.
- **tlast error:** source 2 sends `s_axis_tlast` on beat 4 → `err_tlast` = 1 and stays high. The burst still outputs 12 beats, with `m_axis_tlast` on beat 11 only.
- **Enable mask:** `src_en` = 3'b101 with all sources valid → grant order 0,2,0,2. Clearing `src_en[0]` mid-burst completes that burst.
- **Reset mid-burst:** `rst_n` pulsed low at beat 7 → `m_axis_tvalid` = 0 and `s_axis_tready` = 0 immediately. After release, source 0 is granted first with `beat_cnt` restarted.
